// File: rtl/ip_csc_arb_pkg.sv
// Shared encodings and constants for the colour-convert line arbiter.
package ip_csc_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int SRC_NUM = 2;
    localparam int PAD_VAL = 0;

endpackage

// File: rtl/ip_csc_arb_dly.sv
// W-bit, N-stage delay line with asynchronous active-high clear.
module ip_csc_arb_dly #(
    parameter int W = 2,
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [N-1:0][W-1:0] pipe;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe <= '0;
        end else begin
            pipe[0] <= d;
            for (int i = 1; i < N; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign q = pipe[N-1];

endmodule

// File: rtl/ip_csc_line_arb.sv
// Line-granular round-robin arbiter feeding one RGB->YCbCr converter
// from two FWFT pixel sources, with inter-line gap and aligned source tag.
module ip_csc_line_arb
    import ip_csc_arb_pkg::*;
#(
    parameter int CIW     = 8,
    parameter int LW      = 12,
    parameter int GAP_CYC = 2,
    parameter int CSC_LAT = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [LW-1:0]  i_line_len,
    input  logic           s0_req,
    output logic           s0_gnt,
    output logic           s0_rd,
    input  logic [CIW-1:0] s0_r,
    input  logic [CIW-1:0] s0_g,
    input  logic [CIW-1:0] s0_b,
    input  logic           s1_req,
    output logic           s1_gnt,
    output logic           s1_rd,
    input  logic [CIW-1:0] s1_r,
    input  logic [CIW-1:0] s1_g,
    input  logic [CIW-1:0] s1_b,
    output logic [CIW-1:0] o_data_r,
    output logic [CIW-1:0] o_data_g,
    output logic [CIW-1:0] o_data_b,
    output logic           o_hstr,
    output logic           o_href,
    output logic           o_hend,
    output logic           o_sid,
    output logic           o_sid_vld,
    output logic           o_abort,
    output logic           o_busy
);

    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    state_t              state, state_nxt;
    logic [SRC_NUM-1:0]  req, gnt, rd;
    logic                sid, sid_q, last_win, win, aborted;
    logic [LW-1:0]       len, pix_cnt;
    logic [GW-1:0]       gap_cnt;
    logic                start, last_pix, gap_done, owner_req;
    logic [1:0]          dly_q;

    assign req       = {s1_req, s0_req};
    // Tie goes to whichever source did not win last time.
    assign win       = (req == 2'b11) ? ~last_win : req[1];
    assign start     = (state == IDLE) && (|req) && (i_line_len != '0);
    assign last_pix  = (pix_cnt == len - LW'(1));
    assign gap_done  = (gap_cnt == GW'(GAP_CYC - 1));
    assign owner_req = req[sid];
    assign rd        = (state == XFER && !aborted) ? (gnt & req) : '0;

    assign {s1_gnt, s0_gnt} = gnt;
    assign {s1_rd,  s0_rd}  = rd;
    assign o_busy           = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = XFER;
            XFER:    if (last_pix) state_nxt = (GAP_CYC > 0) ? GAP : IDLE;
            GAP:     if (gap_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt      <= '0;
            sid      <= 1'b0;
            sid_q    <= 1'b0;
            last_win <= 1'b1;
            len      <= '0;
            pix_cnt  <= '0;
            gap_cnt  <= '0;
            aborted  <= 1'b0;
            o_data_r <= '0;
            o_data_g <= '0;
            o_data_b <= '0;
            o_hstr   <= 1'b0;
            o_href   <= 1'b0;
            o_hend   <= 1'b0;
            o_abort  <= 1'b0;
        end else begin
            o_data_r <= CIW'(PAD_VAL);
            o_data_g <= CIW'(PAD_VAL);
            o_data_b <= CIW'(PAD_VAL);
            o_hstr   <= 1'b0;
            o_href   <= 1'b0;
            o_hend   <= 1'b0;
            o_abort  <= 1'b0;
            sid_q    <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    sid      <= win;
                    last_win <= win;
                    len      <= i_line_len;
                    gnt      <= win ? 2'b10 : 2'b01;
                    pix_cnt  <= '0;
                    aborted  <= 1'b0;
                end
                XFER: begin
                    o_href  <= 1'b1;
                    o_hstr  <= (pix_cnt == '0);
                    o_hend  <= last_pix;
                    sid_q   <= sid;
                    pix_cnt <= pix_cnt + LW'(1);
                    gap_cnt <= '0;
                    if (|rd) begin
                        o_data_r <= sid ? s1_r : s0_r;
                        o_data_g <= sid ? s1_g : s0_g;
                        o_data_b <= sid ? s1_b : s0_b;
                    end
                    // Owner gave up: pad out the line, flag once.
                    if (!aborted && !owner_req) begin
                        aborted <= 1'b1;
                        o_abort <= 1'b1;
                    end
                    if (last_pix) gnt <= '0;
                end
                GAP:     gap_cnt <= gap_cnt + GW'(1);
                default: ;
            endcase
        end
    end

    ip_csc_arb_dly #(.W(2), .N(CSC_LAT)) u_dly (
        .clk (clk),
        .rst (rst),
        .d   ({sid_q, o_href}),
        .q   (dly_q)
    );

    assign o_sid     = dly_q[1];
    assign o_sid_vld = dly_q[0];

endmodule

// File: doc/ip_csc_line_arb.md
Name: ip_csc_line_arb

Overview:
Line-granular round-robin arbiter that shares one RGB-to-YCbCr converter between two pixel sources, e.g. the sensor path and a test-pattern/DMA path.
- Grants a whole line to one source, pops its pixels and drives converter inputs with registered R/G/B and hstr/href/hend framing.
- Inserts a programmable inter-line gap.
- Emits a source-ID tag delayed to align with the converter outputs.
- Sits directly upstream of the converter in the colour-convert subsystem.

Parameters:
CIW, 8, pixel component width (R/G/B).
LW, 12, line-length counter width.
GAP_CYC, 2, idle cycles between lines (0 allowed).
CSC_LAT, 4, converter latency in cycles, input framing to output framing.

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active high
i_line_len  in  LW  pixels per line; sampled at grant
s0_req  in  1  source 0 requests a line; held until s0_gnt
s0_gnt  out  1  source 0 owns current line
s0_rd  out  1  pop strobe; source presents pixel in the same cycle (first-word-fall-through)
s0_r/s0_g/s0_b  in  CIW each  source 0 pixel
s1_req, s1_gnt, s1_rd, s1_r/s1_g/s1_b  as source 0
o_data_r/o_data_g/o_data_b  out  CIW each  to converter
o_hstr/o_href/o_hend  out  1 each  to converter framing
o_sid  out  1  source ID aligned with converter outputs
o_sid_vld  out  1  o_href delayed CSC_LAT
o_abort  out  1  one-cycle pulse: owner dropped req mid-line
o_busy  out  1  state != IDLE

Behaviour:
- Reset: all outputs 0; state IDLE; last_win=1, so source 0 wins the first tie; counters 0; delay line cleared. Reset mid-line drops the line immediately. No hend is issued.
- States: IDLE, XFER, GAP.
- IDLE -> XFER
  - Condition: any req and i_line_len != 0.
  - Winner: the single requester; on a tie, the source != last_win.
  - Register sid, len, and sN_gnt=1; update last_win.
  - i_line_len == 0: stay IDLE, no grant.
- XFER
  - sN_rd = gnt[sid] & req[sid], combinational.
  - Output regs load the popped pixel next cycle, so latency is 1 cycle.
  - o_href=1 for exactly len cycles.
  - o_hstr=1 on pixel 0; o_hend=1 on pixel len-1; both on the same cycle when len=1.
  - pix_cnt counts 0..len-1.
  - Last pixel: drop gnt in the same cycle; go to GAP if GAP_CYC>0, else IDLE.
- Abort: owner's req low in XFER.
  - rd stays 0 for the rest of the line.
  - Remaining pixels are padded with zeros so line length stays len.
  - o_abort pulses once, on the first padded cycle.
  - gnt stays high until the line ends.
- GAP: count GAP_CYC cycles, then IDLE. Requests are ignored during GAP. Arbitration is re-evaluated in IDLE, so the minimum line-to-line spacing is GAP_CYC+1 cycles.
- Outside href: o_data_* held at 0.
- o_sid/o_sid_vld: registered sid/o_href through a CSC_LAT-stage shift, aligned with converter o_href.
- i_line_len changes mid-line: ignored.
- req high with no grant pending: no side effect.
- No combinational path from data inputs to outputs.

Decomposition:
- Package ip_csc_arb_pkg holds:
  - state encodings IDLE=2'd0, XFER=2'd1, GAP=2'd2
  - SRC_NUM=2
  - pad value 0
- Sub-module ip_csc_arb_dly: generic W-bit, N-stage shift register with async active-high reset. Instantiated once for {sid, href}, W=2, N=CSC_LAT.

Test Plan:
- s0_req only, len=4, GAP_CYC=2 -> s0_gnt 4 cycles, s0_rd 4 pulses; o_href 4 cycles starting 1 cycle after the first rd; hstr on pixel 0, hend on pixel 3; o_sid_vld rises 4 cycles after o_href with o_sid=0.
- s0_req and s1_req both held, len=3 -> grants alternate s0, s1, s0; 2 idle gap cycles plus 1 IDLE cycle between lines.
- len=1 -> o_hstr and o_hend asserted on the same single href cycle.
- s1 owns line, len=8, s1_req drops after pixel 2 -> pixels 3..7 output as 0; o_abort single pulse; href still 8 cycles; hend on pixel 7.
- i_line_len=0 with s0_req high -> no grant; o_busy stays 0.
- rst asserted in the middle of XFER -> all outputs 0 asynchronously; after release s0 wins the first tie.
